lstm_sequencer: RTL

//  Upstream stage of the lstm cell. Buffers a stream of input samples and

---
 rtl/lstm_pkg.sv | 18 +
 rtl/lstm_fifo.sv | 48 ++++
 rtl/lstm_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// Shared types for the lstm front end: sample format and sequencer states.
package lstm_pkg;

    localparam int WIDTH     = 16;
    localparam int FRAC_BITS = 12;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/lstm_fifo.sv
// Synchronous sample FIFO; wrap-bit pointers separate full from empty.
module lstm_fifo
    import lstm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  sample_t i_data,
    input  logic    i_pop,
    output sample_t o_data,
    output logic    o_empty,
    output logic    o_full
);

    localparam int AW = $clog2(DEPTH);

    sample_t        r_mem [DEPTH];
    logic  [AW:0]   r_wptr;
    logic  [AW:0]   r_rptr;
    logic           w_wr;
    logic           w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/lstm_sequencer.sv
// Upstream sequencer for the lstm cell: buffers samples, issues one timestep at
// a time and feeds the cell's y/C results back as the next h/C inputs.
module lstm_sequencer
    import lstm_pkg::*;
#(
    parameter int WIDTH = lstm_pkg::WIDTH,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] x_in,
    output logic             x_valid,
    input  logic             x_ready,
    output logic [WIDTH-1:0] h_in,
    output logic [WIDTH-1:0] C_in,
    input  logic [WIDTH-1:0] y_out,
    input  logic [WIDTH-1:0] C_out,
    input  logic             y_valid,
    output logic [WIDTH-1:0] h_final,
    output logic             seq_done,
    output logic             err_unexp,
    output seq_state_t       dbg_state
);

    // Handshakes (s_* and x_*): a transfer happens on the posedge where valid
    // and ready are both high; the source holds data stable until then.
    seq_state_t       r_state;
    logic             r_rdy_en;
    logic [WIDTH-1:0] r_x_in;
    logic             r_x_valid;
    logic             r_last;
    logic [WIDTH-1:0] r_h_in;
    logic [WIDTH-1:0] r_c_in;
    logic [WIDTH-1:0] r_h_final;
    logic             r_seq_done;
    logic             r_err;

    sample_t          w_wr_sample;
    sample_t          w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_wr_sample = '{data: s_data, last: s_last};
    assign s_ready     = r_rdy_en && !w_full;
    assign w_push      = s_valid && s_ready;
    assign w_pop       = (r_state == IDLE) && !w_empty;

    lstm_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_wr_sample),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Producer is held off for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rdy_en <= 1'b0;
        else      r_rdy_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_x_in     <= '0;
            r_x_valid  <= 1'b0;
            r_last     <= 1'b0;
            r_h_in     <= '0;
            r_c_in     <= '0;
            r_h_final  <= '0;
            r_seq_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_seq_done <= 1'b0;
            if (y_valid && (r_state != WAIT)) r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_x_in    <= w_head.data;
                        r_last    <= w_head.last;
                        r_x_valid <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_x_valid && x_ready) begin
                        r_x_valid <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (y_valid) begin
                        // End of sequence: publish h and restart the recurrence from zero.
                        if (r_last) begin
                            r_h_final  <= y_out;
                            r_seq_done <= 1'b1;
                            r_h_in     <= '0;
                            r_c_in     <= '0;
                        end else begin
                            r_h_in <= y_out;
                            r_c_in <= C_out;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign x_in      = r_x_in;
    assign x_valid   = r_x_valid;
    assign h_in      = r_h_in;
    assign C_in      = r_c_in;
    assign h_final   = r_h_final;
    assign seq_done  = r_seq_done;
    assign err_unexp = r_err;
    assign dbg_state = r_state;

endmodule
